// File: rtl/vm1_regram_pkg.sv
// vm1_regram shared types, default geometry and the byte-lane merge helper.
package vm1_regram_pkg;

  typedef enum logic {RG_CLEAR, RG_RUN} rg_state_t;

  localparam int VM1_REGRAM_WIDTH = 16;
  localparam int VM1_REGRAM_AW    = 6;

  // rg_merge works on a fixed wide word. Callers widen their operands and
  // size-cast the result back, so any WIDTH up to RG_MAX_WIDTH can share it.
  localparam int RG_MAX_WIDTH = 256;
  localparam int RG_MAX_BYTES = RG_MAX_WIDTH / 8;

  function automatic logic [RG_MAX_WIDTH-1:0] rg_merge(
    input logic [RG_MAX_WIDTH-1:0] old_word,
    input logic [RG_MAX_WIDTH-1:0] new_word,
    input logic [RG_MAX_BYTES-1:0] be
  );
    logic [RG_MAX_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < RG_MAX_BYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vm1_regram_core.sv
// True-dual-port byte-enable RAM array with read-before-write on both ports.
// This is the only place where a vendor primitive may be swapped in. The top
// level guarantees that the two ports never write the same lane of the same
// word on one edge.
module vm1_regram_core
  import vm1_regram_pkg::*;
#(
  parameter int WIDTH = VM1_REGRAM_WIDTH,
  parameter int AW    = VM1_REGRAM_AW
) (
  input  logic               clock,
  input  logic [AW-1:0]      addr_a,
  input  logic [WIDTH-1:0]   din_a,
  input  logic [WIDTH/8-1:0] be_a,
  input  logic               we_a,
  output logic [WIDTH-1:0]   dout_a,
  input  logic [AW-1:0]      addr_b,
  input  logic [WIDTH-1:0]   din_b,
  input  logic [WIDTH/8-1:0] be_b,
  input  logic               we_b,
  output logic [WIDTH-1:0]   dout_b
);

  localparam int BYTES = WIDTH / 8;
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];

  // Both ports in one process: old word to the outputs, enabled lanes written.
  always_ff @(posedge clock) begin
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
    for (int i = 0; i < BYTES; i++) begin
      if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
      if (we_b && be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
    end
  end

endmodule

// File: rtl/vm1_regram.sv
// vm1_regram: dual-port register-file RAM with per-byte write enables,
// per-lane collision resolution (port A wins) and a post-reset clear pass.
// Optional macro VM1_REGRAM_BYPASS_EN compiles in cross-port read forwarding.
// WIDTH must be a multiple of 8 and no larger than RG_MAX_WIDTH.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RG_CLEAR | sequencer owns port A, writes INIT_VALUE to 0..2**AW-1
// RG_RUN   | user ports active; held until the next reset
module vm1_regram
  import vm1_regram_pkg::*;
#(
  parameter int               WIDTH      = VM1_REGRAM_WIDTH,
  parameter int               AW         = VM1_REGRAM_AW,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               ready,
  input  logic [AW-1:0]      address_a,
  input  logic [AW-1:0]      address_b,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  input  logic [WIDTH/8-1:0] byteena_a,
  input  logic [WIDTH/8-1:0] byteena_b,
  input  logic               wren_a,
  input  logic               wren_b,
  output logic [WIDTH-1:0]   q_a,
  output logic [WIDTH-1:0]   q_b
);

  localparam int BYTES = WIDTH / 8;

  rg_state_t        state;
  logic [AW-1:0]    clr_cnt;
  logic             rd_valid;

  logic             run_act;
  logic             seq_wr;
  logic             wr_a;
  logic             wr_b;
  logic             addr_eq;

  logic [AW-1:0]    core_addr_a;
  logic [WIDTH-1:0] core_din_a;
  logic [BYTES-1:0] core_be_a;
  logic             core_we_a;
  logic [BYTES-1:0] core_be_b;
  logic [WIDTH-1:0] core_q_a;
  logic [WIDTH-1:0] core_q_b;

  // Reset is combinationally folded in so that nothing user-driven lands on a
  // reset cycle even though the state register still says RG_RUN.
  assign run_act = (state == RG_RUN) && !reset;
  assign seq_wr  = (state == RG_CLEAR) && !reset;
  assign wr_a    = run_act && wren_a;
  assign wr_b    = run_act && wren_b;
  assign addr_eq = (address_a == address_b);

  // Clear FSM: counter sweeps the array once, then hands over to the user.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RG_CLEAR;
      clr_cnt  <= '0;
      ready    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == RG_RUN);
      case (state)
        RG_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state <= RG_RUN;
            ready <= 1'b1;
          end
        end
        RG_RUN:  state <= RG_RUN;
        default: state <= RG_CLEAR;
      endcase
    end
  end

  // Port-A source select and port-B lane masking on a same-address write.
  always_comb begin
    core_addr_a = address_a;
    core_din_a  = data_a;
    core_be_a   = byteena_a;
    core_we_a   = wr_a;
    core_be_b   = byteena_b;
    if (seq_wr) begin
      core_addr_a = clr_cnt;
      core_din_a  = INIT_VALUE;
      core_be_a   = '1;
      core_we_a   = 1'b1;
    end
    if (wr_a && addr_eq) core_be_b = byteena_b & ~byteena_a;
  end

  vm1_regram_core #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_core (
    .clock  (clock),
    .addr_a (core_addr_a),
    .din_a  (core_din_a),
    .be_a   (core_be_a),
    .we_a   (core_we_a),
    .dout_a (core_q_a),
    .addr_b (address_b),
    .din_b  (data_b),
    .be_b   (core_be_b),
    .we_b   (wr_b),
    .dout_b (core_q_b)
  );

`ifdef VM1_REGRAM_BYPASS_EN
  logic             byp_a_en;
  logic             byp_b_en;
  logic [WIDTH-1:0] byp_a_data;
  logic [WIDTH-1:0] byp_b_data;
  logic [BYTES-1:0] byp_a_be;
  logic [BYTES-1:0] byp_b_be;

  // Capture the other port's write when this port only reads the same word;
  // the merge is applied on top of the core's read-before-write data.
  always_ff @(posedge clock) begin
    byp_a_data <= data_b;
    byp_a_be   <= byteena_b;
    byp_b_data <= data_a;
    byp_b_be   <= byteena_a;
    if (reset) begin
      byp_a_en <= 1'b0;
      byp_b_en <= 1'b0;
    end else begin
      byp_a_en <= wr_b && !wr_a && addr_eq;
      byp_b_en <= wr_a && !wr_b && addr_eq;
    end
  end

  // Output zeroing outside RUN, forwarding merge when a bypass was captured.
  always_comb begin
    q_a = '0;
    q_b = '0;
    if (rd_valid) begin
      q_a = byp_a_en ? WIDTH'(rg_merge(RG_MAX_WIDTH'(core_q_a), RG_MAX_WIDTH'(byp_a_data),
                                       RG_MAX_BYTES'(byp_a_be)))
                     : core_q_a;
      q_b = byp_b_en ? WIDTH'(rg_merge(RG_MAX_WIDTH'(core_q_b), RG_MAX_WIDTH'(byp_b_data),
                                       RG_MAX_BYTES'(byp_b_be)))
                     : core_q_b;
    end
  end
`else
  // Output zeroing outside RUN; cross-port reads see the pre-write word.
  always_comb begin
    q_a = rd_valid ? core_q_a : '0;
    q_b = rd_valid ? core_q_b : '0;
  end
`endif

endmodule

// File: doc/vm1_regram.md
# vm1_regram

Parametrised dual-port register-file RAM for the VM1 core family; successor to the fixed 64x16 register store. Two independent read/write ports on one clock, per-byte write enables on both ports, deterministic cross-port collision resolution, and a post-reset clear sequencer, so contents no longer depend on a vendor init file. Sits between the microsequencer's register-address logic and the datapath, as the general/vector register store.

## Interface
- `WIDTH`, 16: word width in bits; must be a multiple of 8.
- `AW`, 6: address width; depth = 2**AW.
- `INIT_VALUE`, 0: word written to every location by the clear sequencer.
- `clock` in 1: single clock; all ports are sampled on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ready` out 1: high once the clear sequence has finished.
- `address_a`, `address_b` in AW: port addresses.
- `data_a`, `data_b` in WIDTH: write data.
- `byteena_a`, `byteena_b` in WIDTH/8: byte lanes to write.
- `wren_a`, `wren_b` in 1: write strobes.
- `q_a`, `q_b` out WIDTH: registered read data.

## Operation
- **State machine:** two states.
  - CLEAR: entered on any cycle with `reset`=1. The counter starts at 0. Each cycle, internal port A writes `INIT_VALUE` to the counter address, then the counter increments. After address 2**AW-1 the block moves to RUN.
  - RUN: normal operation. The block stays in RUN until the next `reset`.
- **During CLEAR and while `reset`=1:**
  - `ready`=0 and `q_a`=`q_b`=0.
  - User writes are dropped and user reads return 0.
- **Reset during CLEAR:** the counter restarts at 0. A partial clear has no effect beyond rewriting the same value.
- **Write in RUN:** byte lane i of `address_x` takes `data_x[8i+7:8i]` when `wren_x` & `byteena_x[i]`.
- **Read in RUN:** each port reads every cycle, regardless of `wren`.
  - Same-port read/write is read-before-write: `q_x` shows the old word.
- **Both ports write the same address:** resolved per byte. A lane enabled on port A takes port A's data. A lane enabled only on port B takes port B's data.
- **Cross-port read during write (one port reads address X while the other writes X):** `q` returns the old word unless `VM1_REGRAM_BYPASS_EN` is defined.
- **Address range:** addresses are full-range; wrap-around never occurs and there are no illegal addresses.

## Timing
- Read latency is 1 cycle: `q_x` is valid on the edge after the address is sampled. There is no output register stage.
- Write takes effect at the sampling edge. A read of that address on the next cycle returns the new data.
- Reset is released at edge E0. CLEAR then writes addresses 0..2**AW-1 on edges E0..E0+2**AW-1. `ready` rises after edge E0+2**AW-1, i.e. 2**AW cycles after release. User accesses are honoured from the first edge with `ready`=1.
- Reset values: `ready`=0, `q_a`=0, `q_b`=0, counter=0, state=CLEAR.

## Configuration
- `VM1_REGRAM_BYPASS_EN` defined: cross-port forwarding is compiled in.
  - A read on port x of the address written on the same edge by port y returns a merged word: enabled lanes come from y's data, the rest from the stored word.
  - If both ports write and the reading port is itself a writer, its own read stays read-before-write.
- `VM1_REGRAM_BYPASS_EN` undefined: no forwarding logic. Cross-port reads return the pre-write word, which matches a plain READBEFOREWRITE BRAM.

## Structure
- Package `vm1_regram_pkg` holds:
  - the state enum `{RG_CLEAR, RG_RUN}`;
  - constants `VM1_REGRAM_WIDTH`=16 and `VM1_REGRAM_AW`=6;
  - the byte-merge function `rg_merge(old, new, be)`.
- Sub-module `vm1_regram_core`: an inferable true-dual-port byte-enable array with read-before-write on both ports. It is the only place a vendor primitive may be substituted.
- The top level holds:
  - the clear FSM and counter;
  - the port-A/sequencer mux;
  - collision masking (port B's lanes gated by ~`byteena_a` on an address match);
  - optional bypass and output zeroing.

## Test plan
- **Clear sequence:** hold `reset` 3 cycles, release with `INIT_VALUE`=16'hA5A5. `ready` must rise exactly 64 cycles later, and reads of addresses 0, 31 and 63 return A5A5.
- **Reset mid-clear:** assert `reset` at counter=20. `ready` must rise 64 cycles after the second release, and no user write during CLEAR (wren_a, addr 5, data 1234) lands.
- **Byte lanes:** write 16'h1122 to address 7 with `byteena_a`=2'b01, after 16'hFFFF. Address 7 must read FF22.
- **Collision:** A writes 16'hAAAA with be 2'b10, and B writes 16'hBBBB with be 2'b11, both to address 9 on one edge. Address 9 must read AABB.
- **Cross-port read during write:** A writes 16'h5555 to address 3 (old value 0001) while B reads address 3.
  - Without the macro, `q_b`=0001.
  - With the macro, `q_b`=5555.
  - In both builds, A's own `q_a`=0001.
- **Back-to-back streaming:** both ports write and read distinct addresses every cycle for 200 random cycles. Results must match a reference model with 1-cycle read latency.
